// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with 16x oversampling and majority-vote bit
// recovery. An optional even-parity bit is enabled by defining the macro
// UART_RX_PARITY_EN (default build: no parity bit, parity_err tied low).
//
// Parameters
//   CLK_HZ          input clock frequency in Hz
//   BAUD            serial bit rate
// Ports
//   FPGA_CLK1_50    in   sole clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   RxD             in   serial line (idle high, LSB first, 1 stop bit)
//   RxD_ack         in   consumer acknowledge for the held byte
//   RxD_data        out  [7:0] last accepted byte
//   RxD_data_ready  out  high while an unacknowledged byte is held
//   RxD_idle        out  high while the receiver FSM is idle
//   frame_err       out  one-cycle pulse: stop bit sampled low
//   parity_err      out  one-cycle pulse: parity mismatch
//   overrun         out  sticky: a byte completed while one was still held
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       FPGA_CLK1_50,
  input  logic       reset_n,
  input  logic       RxD,
  input  logic       RxD_ack,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_idle,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  // Rounded divider for the 16x oversample tick.
  localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e        state_q, state_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]    phase_q, phase_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          s7_q, s7_d, s8_q, s8_d;
  logic          drop_q, drop_d;       // byte already condemned (bad parity)
  logic          stop_wait_q, stop_wait_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
`endif

  logic tick, fall, vote, at9, byte_done, ack_eff;

  assign tick = (div_cnt_q == DW'(DIV - 1));
  assign fall = rx_prev_q & ~rx_s2_q;
  // Ticks 7 and 8 are stored; tick 9 uses the live synchronised level.
  assign vote = (s7_q & s8_q) | (s7_q & rx_s2_q) | (s8_q & rx_s2_q);
  assign at9  = tick && (phase_q == 4'd9);
  assign ack_eff = RxD_ack & ready_q;

  // Synchroniser plus one extra flop for falling-edge detection.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RxD;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      phase_q     <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      s7_q        <= 1'b0;
      s8_q        <= 1'b0;
      drop_q      <= 1'b0;
      stop_wait_q <= 1'b0;
      data_q      <= 8'h00;
      ready_q     <= 1'b0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      drop_q      <= drop_d;
      stop_wait_q <= stop_wait_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  // Receive FSM. Each state acts on tick 9 of its bit; the phase counter
  // keeps running, so the next state's ticks 7..9 fall in the next bit.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + DW'(1);
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    drop_d      = drop_q;
    stop_wait_d = stop_wait_q;
    ferr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d      = 1'b0;
`endif
    byte_done   = 1'b0;

    if (tick) begin
      phase_d = phase_q + 4'd1;
      if (phase_q == 4'd7) s7_d = rx_s2_q;
      if (phase_q == 4'd8) s8_d = rx_s2_q;
    end

    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (fall) begin
          state_d     = S_START;
          div_cnt_d   = '0;
          bit_cnt_d   = '0;
          drop_d      = 1'b0;
          stop_wait_d = 1'b0;
        end
      end
      S_START: begin
        // A high vote means the edge was a glitch: back to idle silently.
        if (at9) state_d = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (at9) begin
          shreg_d   = {vote, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at9) begin
          // Even parity: data bits plus parity bit hold an even count of ones.
          if (vote != ^shreg_q) begin
            perr_d = 1'b1;
            drop_d = 1'b1;
          end
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (stop_wait_q) begin
          // After a framing error, re-arm only once the line is back high.
          if (rx_s2_q) begin
            state_d     = S_IDLE;
            stop_wait_d = 1'b0;
          end
        end else if (at9) begin
          if (vote) begin
            state_d   = S_IDLE;
            byte_done = ~drop_q;
          end else begin
            ferr_d      = 1'b1;
            stop_wait_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register. A completing byte wins over a simultaneous ack.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    if (byte_done && ready_q && !RxD_ack) begin
      ovr_d = 1'b1;
    end else if (byte_done) begin
      data_d  = shreg_q;
      ready_d = 1'b1;
      if (ack_eff) ovr_d = 1'b0;
    end else if (ack_eff) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign RxD_data       = data_q;
  assign RxD_data_ready = ready_q;
  assign RxD_idle       = (state_q == S_IDLE);
  assign frame_err      = ferr_q;
  assign overrun        = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err     = perr_q;
`else
  assign parity_err     = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have port FPGA_CLK1_50  input  1  sole clock; all flops on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RxD  input  1  serial line; idle high, 8 data bits, LSB first, 1 stop bit.
REQ-006 SHALL have port RxD_ack  input  1  consumer acknowledge for the held byte.
REQ-007 SHALL have port RxD_data  output  8  last accepted byte.
REQ-008 SHALL have port RxD_data_ready  output  1  level; high while an unacknowledged byte is held.
REQ-009 SHALL have port RxD_idle  output  1  high in the IDLE state.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse; parity mismatch (tied 0 when the parity option is absent).
REQ-012 SHALL have port overrun  output  1  sticky; set when a byte completes while RxD_data_ready=1.

Function
REQ-013 SHALL pass RxD through a two-flop synchroniser before any other use.
REQ-014 SHALL derive a 16x oversample tick from a counter reloading at DIV-1, where DIV=round(CLK_HZ/(16*BAUD)); the counter runs freely in IDLE.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-016 SHALL leave IDLE for START on a synchronised falling edge and zero the tick-phase counter.
REQ-017 SHALL resolve each bit by majority vote of oversample ticks 7, 8 and 9 within that bit.
REQ-018 SHALL return to IDLE from START without any output change if the start-bit vote is 1 (glitch rejection).
REQ-019 SHALL, in DATA, shift 8 bits LSB first, using a 3-bit bit counter that wraps from 7 into the next state.
REQ-020 SHALL, in STOP with a stop vote of 1 and RxD_data_ready=0, load RxD_data and set RxD_data_ready in the cycle after tick 9.
REQ-021 SHALL, in STOP with a stop vote of 1 and RxD_data_ready=1, leave RxD_data unchanged, set overrun and discard the new byte.
REQ-022 SHALL, in STOP with a stop vote of 0, pulse frame_err for one cycle, discard the byte, and wait in STOP until RxD is high before entering IDLE.
REQ-023 SHALL enter IDLE after tick 9 of a good stop bit, so that back-to-back frames are received.
REQ-024 SHALL clear RxD_data_ready on the clock after RxD_ack=1.
REQ-025 SHALL give priority to the new byte when RxD_ack and byte completion occur in the same cycle: the new byte is loaded, ready stays 1, and overrun is not set.
REQ-026 SHALL clear overrun only on RxD_ack=1 or on reset.
REQ-027 SHALL ignore RxD_ack while RxD_data_ready=0.

Reset
REQ-028 SHALL, with reset_n=0, force state to IDLE, both synchroniser flops to 1, all counters to 0, RxD_data to 8'h00, RxD_data_ready, frame_err, parity_err and overrun to 0, and RxD_idle to 1.
REQ-029 SHALL, on reset asserted mid-frame, discard the partial byte; after release, reception resumes only on the next falling edge.

Configuration
REQ-030 SHALL, with UART_RX_PARITY_EN defined, expect one even-parity bit between the data bits and the stop bit (PARITY state).
REQ-031 SHALL, with UART_RX_PARITY_EN defined and the parity vote mismatching, pulse parity_err for one cycle and discard the byte (no ready, no overrun).
REQ-032 SHALL, without UART_RX_PARITY_EN, omit the PARITY state, go from DATA directly to STOP, and tie parity_err to 0.

Verification
REQ-033 SHALL verify: frame 0x55 sent at 115200 baud, then ack -> RxD_data=8'h55, RxD_data_ready high until one cycle after ack, no error pulses.
REQ-034 SHALL verify: frame 0xA3 with the stop bit driven low -> one frame_err pulse, RxD_data_ready stays 0, next frame 0x0F received correctly.
REQ-035 SHALL verify: a 2 us low glitch on idle RxD -> state returns to IDLE, no outputs change.
REQ-036 SHALL verify: frames 0x31 then 0x32 back-to-back with no ack -> RxD_data=8'h31, overrun=1; after ack, overrun=0 and ready=0.
REQ-037 SHALL verify: reset_n pulsed low during data bit 4 of 0xFF -> outputs at reset values, no byte delivered, following frame 0x12 received.
REQ-038 SHALL verify, with UART_RX_PARITY_EN: 0x07 sent with parity bit 0 -> one parity_err pulse, ready stays 0; with parity bit 1 -> byte 0x07 delivered.
